// File: rtl/uart_pkg.sv
// Shared UART definitions for the parametrised receiver and the future transmitter.
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, oversample tick counter and 3-vote majority sampler.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  input  logic tick,
  input  logic active,
  output logic rxs,
  output logic bit_val,
  output logic bit_noise,
  output logic bit_strobe,
  output logic bit_end
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] V0   = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] V1   = TW'(OVERSAMPLE/2);
  localparam logic [TW-1:0] V2   = TW'(OVERSAMPLE/2 + 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  logic [1:0]    sync_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          v0_q, v0_d, v1_q, v1_d;
  logic          adv;

  assign rxs = sync_q[1];
  assign adv = active & tick;

  // Counter is held at 0 while idle so a new frame always starts aligned.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    if (!active)   tick_cnt_d = '0;
    else if (tick) tick_cnt_d = (tick_cnt_q == LAST) ? '0 : tick_cnt_q + 1'b1;
    if (adv && tick_cnt_q == V0) v0_d = rxs;
    if (adv && tick_cnt_q == V1) v1_d = rxs;
  end

  // Third vote is the live sample, so the verdict is ready on the V2 tick.
  assign bit_strobe = adv && (tick_cnt_q == V2);
  assign bit_end    = adv && (tick_cnt_q == LAST);
  assign bit_val    = maj3(v0_q, v1_q, rxs);
  assign bit_noise  = (v0_q != v1_q) || (v1_q != rxs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      tick_cnt_q <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rxd};
      tick_cnt_q <= tick_cnt_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
    end
  end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM with parity, stop-bit and noise reporting.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx_EN,
  input  logic                 RxD,
  input  logic                 Rx_sample_ENABLE,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_valid,
  output logic                 Rx_FERROR,
  output logic                 Rx_PERROR,
  output logic                 Rx_NOISE,
  output logic                 Rx_busy
);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 pe_acc_q, pe_acc_d, fe_acc_q, fe_acc_d, ne_acc_q, ne_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d, fe_q, fe_d, pe_q, pe_d, ne_q, ne_d;

  logic rxs, bit_val, bit_noise, bit_strobe, bit_end;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk        (clk),
    .rst        (reset),
    .rxd        (RxD),
    .tick       (Rx_sample_ENABLE),
    .active     (state_q != IDLE),
    .rxs        (rxs),
    .bit_val    (bit_val),
    .bit_noise  (bit_noise),
    .bit_strobe (bit_strobe),
    .bit_end    (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    pe_acc_d   = pe_acc_q;
    fe_acc_d   = fe_acc_q;
    ne_acc_d   = ne_acc_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    fe_d       = fe_q;
    pe_d       = pe_q;
    ne_d       = ne_q;
    if (!Rx_EN) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (Rx_sample_ENABLE && !rxs) begin
          state_d  = START;
          par_d    = 1'b0;
          pe_acc_d = 1'b0;
          fe_acc_d = 1'b0;
          ne_acc_d = 1'b0;
        end
        START: begin
          if (bit_strobe) begin
            ne_acc_d = bit_noise;
            if (bit_val) state_d = IDLE;
          end
          if (bit_end) begin
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end
        DATA: begin
          if (bit_strobe) begin
            shift_d  = {bit_val, shift_q[DATA_BITS-1:1]};
            par_d    = par_q ^ bit_val;
            ne_acc_d = ne_acc_q | bit_noise;
          end
          if (bit_end) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              state_d    = (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
              stop_cnt_d = 1'b0;
            end
          end
        end
        PARITY: begin
          if (bit_strobe) begin
            pe_acc_d = (PARITY_MODE == PARITY_ODD) ? ~(par_q ^ bit_val) : (par_q ^ bit_val);
            ne_acc_d = ne_acc_q | bit_noise;
          end
          if (bit_end) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
          end
        end
        STOP: begin
          // Leave at the last stop vote, giving half a bit of resync margin.
          if (bit_strobe) begin
            fe_acc_d = fe_acc_q | ~bit_val;
            ne_acc_d = ne_acc_q | bit_noise;
            if ((STOP_BITS == 1) || (stop_cnt_q == 1'b1)) begin
              state_d = IDLE;
              valid_d = 1'b1;
              data_d  = shift_q;
              fe_d    = fe_acc_d;
              pe_d    = pe_acc_q;
              ne_d    = ne_acc_d;
            end
          end
          if (bit_end) stop_cnt_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      pe_acc_q   <= 1'b0;
      fe_acc_q   <= 1'b0;
      ne_acc_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      ne_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      pe_acc_q   <= pe_acc_d;
      fe_acc_q   <= fe_acc_d;
      ne_acc_q   <= ne_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      ne_q       <= ne_d;
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_valid  = valid_q;
  assign Rx_FERROR = fe_q;
  assign Rx_PERROR = pe_q;
  assign Rx_NOISE  = ne_q;
  assign Rx_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: default instance (A) and 7-bit/odd/2-stop/x8 instance (B).
module tb_uart_rx_param;
  localparam int OA = 16;
  localparam int OB = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic en_a = 1'b1, rxd_a = 1'b1, tick_a = 1'b0;
  logic en_b = 1'b1, rxd_b = 1'b1, tick_b = 1'b0;
  logic [7:0] data_a;
  logic       vld_a, fe_a, pe_a, ne_a, busy_a;
  logic [6:0] data_b;
  logic       vld_b, fe_b, pe_b, ne_b, busy_b;

  int checks = 0, errors = 0;
  int pulses_a = 0, pulses_b = 0, dbl = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  logic smp[$];
  int   vote_idx;
  logic [7:0] last_a = 8'h00;
  logic [2:0] last_flags_a = 3'b000;

  uart_rx_param u_a (
    .clk(clk), .reset(reset), .Rx_EN(en_a), .RxD(rxd_a), .Rx_sample_ENABLE(tick_a),
    .Rx_DATA(data_a), .Rx_valid(vld_a), .Rx_FERROR(fe_a), .Rx_PERROR(pe_a),
    .Rx_NOISE(ne_a), .Rx_busy(busy_a));

  uart_rx_param #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .OVERSAMPLE(OB)) u_b (
    .clk(clk), .reset(reset), .Rx_EN(en_b), .RxD(rxd_b), .Rx_sample_ENABLE(tick_b),
    .Rx_DATA(data_b), .Rx_valid(vld_b), .Rx_FERROR(fe_b), .Rx_PERROR(pe_b),
    .Rx_NOISE(ne_b), .Rx_busy(busy_b));

  always @(posedge clk) begin
    if (vld_a) pulses_a <= pulses_a + 1;
    if (vld_b) pulses_b <= pulses_b + 1;
    if ((vld_a && prev_a) || (vld_b && prev_b)) dbl <= dbl + 1;
    prev_a <= vld_a;
    prev_b <= vld_b;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One oversample tick: line settles through the synchroniser before the tick.
  task automatic tick_sample(input bit sel, input logic v, output logic vs);
    if (sel) rxd_b = v; else rxd_a = v;
    @(negedge clk);
    @(negedge clk);
    if (sel) tick_b = 1'b1; else tick_a = 1'b1;
    @(negedge clk);
    tick_a = 1'b0;
    tick_b = 1'b0;
    vs = sel ? vld_b : vld_a;
  endtask

  task automatic play(input bit sel, input int n, output bit lat_ok);
    logic vs;
    lat_ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick_sample(sel, smp[i], vs);
      if (i == vote_idx && vs === 1'b1) lat_ok = 1'b1;
    end
  endtask

  task automatic idle(input bit sel, input int n);
    logic vs;
    for (int i = 0; i < n; i++) tick_sample(sel, 1'b1, vs);
  endtask

  // Serial frame expanded to one line value per oversample tick.
  task automatic build(input int nb, input int pm, input int ns, input int os,
                       input logic [8:0] data, input bit flip_par, input bit stop_zero);
    logic bits[$];
    logic p;
    smp.delete();
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(data[i]);
      p = p ^ data[i];
    end
    if (pm != 0) bits.push_back(((pm == 2) ? ~p : p) ^ flip_par);
    for (int s = 0; s < ns; s++) bits.push_back((s == 0 && stop_zero) ? 1'b0 : 1'b1);
    foreach (bits[b]) for (int k = 0; k < os; k++) smp.push_back(bits[b]);
    vote_idx = (bits.size() - 1) * os + os / 2 + 2;
  endtask

  // Reference: each bit is decided by the three ticks around its centre.
  task automatic model(input int nb, input int pm, input int ns, input int os,
                       output logic [8:0] d, output logic fe, output logic pe, output logic ne);
    int base, cnt, nbits;
    logic v, p;
    d = '0; fe = 1'b0; pe = 1'b0; ne = 1'b0; p = 1'b0;
    nbits = 1 + nb + ((pm != 0) ? 1 : 0) + ns;
    for (int b = 0; b < nbits; b++) begin
      base = b * os + os / 2;
      cnt = int'(smp[base]) + int'(smp[base+1]) + int'(smp[base+2]);
      v = (cnt >= 2);
      if (cnt == 1 || cnt == 2) ne = 1'b1;
      if (b >= 1 && b <= nb) begin
        d[b-1] = v;
        p = p ^ v;
      end else if (pm != 0 && b == nb + 1) begin
        pe = (pm == 2) ? ~(p ^ v) : (p ^ v);
      end else if (b > nb && !v) begin
        fe = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({data_a, vld_a, fe_a, pe_a, ne_a, busy_a} !== 13'h0) begin
      errors++;
      $display("FAIL reset_a: got %h want 0", {data_a, vld_a, fe_a, pe_a, ne_a, busy_a});
    end
    checks++;
    if ({data_b, vld_b, fe_b, pe_b, ne_b, busy_b} !== 12'h0) begin
      errors++;
      $display("FAIL reset_b: got %h want 0", {data_b, vld_b, fe_b, pe_b, ne_b, busy_b});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frames();
    logic [7:0] td[5]     = '{8'hA5, 8'h3C, 8'h3C, 8'h55, 8'h00};
    bit         tflip[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bit         tstop[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int         tgl[5]    = '{-1, -1, -1, -1, 3*OA + OA/2 + 1};
    logic [2:0] tflags[5] = '{3'b000, 3'b010, 3'b000, 3'b100, 3'b001};
    bit lat;
    int p0;
    for (int k = 0; k < 5; k++) begin
      build(8, 1, 1, OA, {1'b0, td[k]}, tflip[k], tstop[k]);
      if (tgl[k] >= 0) smp[tgl[k]] = ~smp[tgl[k]];
      p0 = pulses_a;
      play(0, smp.size(), lat);
      idle(0, OA + 4);
      checks++;
      if (lat !== 1'b1) begin errors++; $display("FAIL frame%0d_latency: got %b want 1", k, lat); end
      checks++;
      if (pulses_a - p0 != 1) begin errors++; $display("FAIL frame%0d_pulses: got %0d want 1", k, pulses_a - p0); end
      checks++;
      if (data_a !== td[k]) begin errors++; $display("FAIL frame%0d_data: got %h want %h", k, data_a, td[k]); end
      checks++;
      if ({fe_a, pe_a, ne_a} !== tflags[k]) begin
        errors++;
        $display("FAIL frame%0d_flags(fe,pe,ne): got %b want %b", k, {fe_a, pe_a, ne_a}, tflags[k]);
      end
      checks++;
      if (busy_a !== 1'b0) begin errors++; $display("FAIL frame%0d_busy: got %b want 0", k, busy_a); end
      last_a = td[k];
      last_flags_a = tflags[k];
    end
  endtask

  task automatic test_random();
    logic [8:0] ed;
    logic efe, epe, ene;
    bit lat;
    int p0, g;
    for (int k = 0; k < 20; k++) begin
      build(8, 1, 1, OA, {1'b0, 8'($urandom_range(0, 255))},
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        g = $urandom_range(OA, 10 * OA - 1);
        smp[g] = ~smp[g];
      end
      model(8, 1, 1, OA, ed, efe, epe, ene);
      p0 = pulses_a;
      play(0, smp.size(), lat);
      idle(0, OA + 4);
      checks++;
      if (lat !== 1'b1 || pulses_a - p0 != 1) begin
        errors++;
        $display("FAIL rand%0d_valid: latency_ok %b pulses %0d want 1/1", k, lat, pulses_a - p0);
      end
      checks++;
      if (data_a !== ed[7:0]) begin errors++; $display("FAIL rand%0d_data: got %h want %h", k, data_a, ed[7:0]); end
      checks++;
      if ({fe_a, pe_a, ne_a} !== {efe, epe, ene}) begin
        errors++;
        $display("FAIL rand%0d_flags(fe,pe,ne): got %b want %b", k, {fe_a, pe_a, ne_a}, {efe, epe, ene});
      end
      last_a = ed[7:0];
      last_flags_a = {efe, epe, ene};
    end
  endtask

  task automatic test_false_start();
    int p0;
    p0 = pulses_a;
    smp.delete();
    for (int i = 0; i < 4; i++) smp.push_back(1'b0);
    vote_idx = -1;
    begin
      bit lat;
      play(0, 4, lat);
    end
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL false_start_busy_high: got %b want 1", busy_a); end
    idle(0, OA + 4);
    checks++;
    if (pulses_a - p0 != 0) begin errors++; $display("FAIL false_start_pulses: got %0d want 0", pulses_a - p0); end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL false_start_busy_low: got %b want 0", busy_a); end
    checks++;
    if (data_a !== last_a) begin errors++; $display("FAIL false_start_data: got %h want %h", data_a, last_a); end
  endtask

  task automatic test_abort_reset();
    bit lat;
    int p0;
    build(8, 1, 1, OA, {1'b0, 8'($urandom_range(0, 255))}, 1'b0, 1'b0);
    p0 = pulses_a;
    play(0, 5 * OA + OA / 2, lat);
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy_a); end
    en_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b want 0", busy_a); end
    en_a = 1'b1;
    idle(0, OA + 4);
    checks++;
    if (pulses_a - p0 != 0) begin errors++; $display("FAIL abort_pulses: got %0d want 0", pulses_a - p0); end
    checks++;
    if ({data_a, fe_a, pe_a, ne_a} !== {last_a, last_flags_a}) begin
      errors++;
      $display("FAIL abort_outputs_held: got %h want %h", {data_a, fe_a, pe_a, ne_a}, {last_a, last_flags_a});
    end

    build(8, 1, 1, OA, {1'b0, 8'($urandom_range(0, 255))}, 1'b0, 1'b0);
    play(0, 7 * OA, lat);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({data_a, vld_a, fe_a, pe_a, ne_a, busy_a} !== 13'h0) begin
      errors++;
      $display("FAIL midframe_reset_outputs: got %h want 0", {data_a, vld_a, fe_a, pe_a, ne_a, busy_a});
    end
    reset = 1'b0;
    idle(0, 4);
    checks++;
    if (pulses_a - p0 != 0) begin errors++; $display("FAIL midframe_reset_pulses: got %0d want 0", pulses_a - p0); end

    build(8, 1, 1, OA, 9'h0FF, 1'b0, 1'b0);
    play(0, smp.size(), lat);
    idle(0, OA + 4);
    checks++;
    if (lat !== 1'b1 || pulses_a - p0 != 1) begin
      errors++;
      $display("FAIL after_reset_valid: latency_ok %b pulses %0d want 1/1", lat, pulses_a - p0);
    end
    checks++;
    if ({data_a, fe_a, pe_a, ne_a} !== {8'hFF, 3'b000}) begin
      errors++;
      $display("FAIL after_reset_frame: got %h want %h", {data_a, fe_a, pe_a, ne_a}, {8'hFF, 3'b000});
    end
  endtask

  task automatic test_back_to_back();
    bit lat;
    int p0;
    p0 = pulses_b;
    for (int k = 0; k < 3; k++) begin
      build(7, 2, 2, OB, 9'h041, 1'b0, 1'b0);
      play(1, smp.size(), lat);
      checks++;
      if (lat !== 1'b1) begin errors++; $display("FAIL b2b%0d_latency: got %b want 1", k, lat); end
      checks++;
      if ({data_b, fe_b, pe_b, ne_b} !== {7'h41, 3'b000}) begin
        errors++;
        $display("FAIL b2b%0d_frame: got %h want %h", k, {data_b, fe_b, pe_b, ne_b}, {7'h41, 3'b000});
      end
    end
    idle(1, OB + 4);
    checks++;
    if (pulses_b - p0 != 3) begin errors++; $display("FAIL b2b_pulses: got %0d want 3", pulses_b - p0); end
    checks++;
    if (busy_b !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", busy_b); end
    checks++;
    if (dbl != 0) begin errors++; $display("FAIL valid_width: got %0d multi-cycle pulses want 0", dbl); end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_random();
    test_false_start();
    test_abort_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
